// File: rtl/bus_timer_pkg.sv
`default_nettype none
// ============================================================================
// Module  : bus_timer_pkg
// Brief   : Register offsets, window base and byte-merge helper for bus_timer
// Revision: 1.0
// ============================================================================
package bus_timer_pkg;

    typedef enum logic [1:0] {
        REG_CTRL  = 2'h0,
        REG_LOAD  = 2'h1,
        REG_COUNT = 2'h2,
        REG_STAT  = 2'h3
    } reg_sel_e;

    localparam logic [31:0] c_TIMER_BASE = 32'h1000_0000;

    // Byte lanes with sel set take the new value, others keep the old one.
    function automatic logic [31:0] byte_merge(input logic [31:0] old_val,
                                               input logic [31:0] new_val,
                                               input logic [3:0]  sel);
        logic [31:0] result;
        result = old_val;
        for (int i = 0; i < 4; i++) begin
            if (sel[i]) begin
                result[8*i +: 8] = new_val[8*i +: 8];
            end
        end
        return result;
    endfunction

endpackage
`default_nettype wire

// File: rtl/bus_timer_if.sv
`default_nettype none
// ============================================================================
// Module  : bus_timer_if
// Brief   : CPU data-bus slave interface of the memory-mapped timer
// Revision: 1.0
// ============================================================================
interface bus_timer_if;
    logic        ce_i;
    logic        we_i;
    logic [31:0] addr_i;
    logic [3:0]  sel_i;
    logic [31:0] data_i;
    logic [31:0] data_o;

    modport master (
        output ce_i, we_i, addr_i, sel_i, data_i,
        input  data_o
    );

    modport slave (
        input  ce_i, we_i, addr_i, sel_i, data_i,
        output data_o
    );
endinterface
`default_nettype wire

// File: rtl/bus_timer_prescaler.sv
`default_nettype none
// ============================================================================
// Module  : timer_prescaler
// Brief   : Divides clk by PRESCALE_DIV into a one-cycle count tick
// Revision: 1.0
// ============================================================================
module timer_prescaler #(
    parameter int PRESCALE_DIV = 4,
    parameter int PRESCALE_W   = 8
) (
    input  wire logic clk,
    input  wire logic rst,
    input  wire logic en,
    input  wire logic clr,
    output logic      tick
);

    localparam logic [PRESCALE_W-1:0] c_DIV_M1 = PRESCALE_W'(PRESCALE_DIV - 1);

    logic [PRESCALE_W-1:0] r_presc;

    assign tick = en & (r_presc == c_DIV_M1);

    // The phase freezes while disabled; clr restarts it on re-enable.
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            r_presc <= '0;
        end else if (en) begin
            if (tick) begin
                r_presc <= '0;
            end else begin
                r_presc <= r_presc + 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/bus_timer.sv
`default_nettype none
// ============================================================================
// Module  : bus_timer
// Brief   : Memory-mapped down-counting timer with level interrupt on expiry
// Revision: 1.0
// ============================================================================
module bus_timer
    import bus_timer_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR    = c_TIMER_BASE,
    parameter int          PRESCALE_DIV = 4,
    parameter int          PRESCALE_W   = 8
) (
    input  wire logic      clk,
    input  wire logic      rst,
    bus_timer_if.slave     bus,
    output logic           irq_o
);

    logic        r_en;
    logic        r_autoreload;
    logic        r_ien;
    logic        r_pending;
    logic [31:0] r_load;
    logic [31:0] r_count;

    logic        w_hit;
    logic        w_wr;
    reg_sel_e    w_reg;
    logic        w_wr_ctrl;
    logic        w_wr_load;
    logic        w_wr_count;
    logic        w_w1c;
    logic        w_tick;
    logic        w_tick_eff;
    logic        w_expire;
    logic        w_presc_clr;
    logic [31:0] w_rdata;
    logic [1:0]  w_unused_addr;

    assign w_unused_addr = bus.addr_i[1:0];

    assign w_hit       = bus.ce_i & ~rst & (bus.addr_i[31:4] == BASE_ADDR[31:4]);
    assign w_wr        = w_hit & bus.we_i;
    assign w_reg       = reg_sel_e'(bus.addr_i[3:2]);
    assign w_wr_ctrl   = w_wr & (w_reg == REG_CTRL) & bus.sel_i[0];
    assign w_wr_load   = w_wr & (w_reg == REG_LOAD);
    assign w_wr_count  = w_wr & (w_reg == REG_COUNT) & (|bus.sel_i);
    assign w_w1c       = w_wr & (w_reg == REG_STAT) & bus.sel_i[0] & bus.data_i[0];
    assign w_presc_clr = w_wr_ctrl & bus.data_i[0] & ~r_en;

    // A COUNT write swallows a coincident tick, including its expiry.
    assign w_tick_eff  = w_tick & ~w_wr_count;
    assign w_expire    = w_tick_eff & (r_count == '0);

    timer_prescaler #(
        .PRESCALE_DIV (PRESCALE_DIV),
        .PRESCALE_W   (PRESCALE_W)
    ) u_prescaler (
        .clk  (clk),
        .rst  (rst),
        .en   (r_en),
        .clr  (w_presc_clr),
        .tick (w_tick)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_en         <= 1'b0;
            r_autoreload <= 1'b0;
            r_ien        <= 1'b0;
            r_pending    <= 1'b0;
            r_load       <= '0;
            r_count      <= '0;
        end else begin
            if (w_wr_ctrl) begin
                {r_ien, r_autoreload, r_en} <= bus.data_i[2:0];
            end else if (w_expire && !r_autoreload) begin
                r_en <= 1'b0;
            end

            if (w_wr_load) begin
                r_load <= byte_merge(r_load, bus.data_i, bus.sel_i);
            end

            if (w_wr_count) begin
                r_count <= byte_merge(r_count, bus.data_i, bus.sel_i);
            end else if (w_tick_eff) begin
                if (r_count != '0) begin
                    r_count <= r_count - 32'd1;
                end else if (r_autoreload) begin
                    r_count <= r_load;
                end
            end

            // Expiry set outranks a same-cycle clear.
            if (w_expire) begin
                r_pending <= 1'b1;
            end else if (w_w1c) begin
                r_pending <= 1'b0;
            end
        end
    end

    always_comb begin
        w_rdata = '0;
        if (w_hit && !bus.we_i) begin
            case (w_reg)
                REG_CTRL:  w_rdata = {29'd0, r_ien, r_autoreload, r_en};
                REG_LOAD:  w_rdata = r_load;
                REG_COUNT: w_rdata = r_count;
                REG_STAT:  w_rdata = {31'd0, r_pending};
                default:   w_rdata = '0;
            endcase
        end
    end

    assign bus.data_o = w_rdata;
    assign irq_o      = r_pending & r_ien & ~rst;

endmodule
`default_nettype wire

// File: tb/tb_bus_timer.sv
`default_nettype none
// ============================================================================
// Module  : tb_bus_timer
// Brief   : Directed and randomized self-checking bench for bus_timer
// Revision: 1.0
// ============================================================================
module tb_bus_timer;
    import bus_timer_pkg::*;

    localparam int          DIV  = 4;
    localparam logic [31:0] BASE = 32'h1000_0000;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic irq_o;

    int vectors     = 0;
    int miscompares = 0;

    bus_timer_if bus ();

    bus_timer #(
        .BASE_ADDR    (BASE),
        .PRESCALE_DIV (DIV),
        .PRESCALE_W   (8)
    ) dut (
        .clk   (clk),
        .rst   (rst),
        .bus   (bus),
        .irq_o (irq_o)
    );

    always #5 clk = ~clk;

    // Reference model: timer state plus cycles remaining until the next tick.
    logic        m_en   = 1'b0;
    logic        m_ar   = 1'b0;
    logic        m_ien  = 1'b0;
    logic        m_pend = 1'b0;
    logic [31:0] m_load  = '0;
    logic [31:0] m_count = '0;
    int          m_wait  = DIV;

    function automatic logic [31:0] lanes(input logic [31:0] old_v, input logic [31:0] new_v,
                                          input logic [3:0] sel);
        logic [31:0] r;
        for (int b = 0; b < 4; b++) begin
            r[8*b +: 8] = sel[b] ? new_v[8*b +: 8] : old_v[8*b +: 8];
        end
        return r;
    endfunction

    function automatic logic model_hit();
        return bus.ce_i && (bus.addr_i[31:4] == BASE[31:4]);
    endfunction

    function automatic logic [31:0] model_read();
        if (rst || !model_hit() || bus.we_i) return 32'd0;
        case (bus.addr_i[3:2])
            2'd0:    return {29'd0, m_ien, m_ar, m_en};
            2'd1:    return m_load;
            2'd2:    return m_count;
            default: return {31'd0, m_pend};
        endcase
    endfunction

    task automatic model_step();
        logic        wr, tick, cnt_wr;
        logic [1:0]  off;
        logic        n_en, n_ar, n_ien, n_pend;
        logic [31:0] n_load, n_count;
        int          n_wait;
        if (rst) begin
            m_en = 0; m_ar = 0; m_ien = 0; m_pend = 0;
            m_load = 0; m_count = 0; m_wait = DIV;
            return;
        end
        wr     = model_hit() && bus.we_i;
        off    = bus.addr_i[3:2];
        tick   = m_en && (m_wait == 1);
        cnt_wr = wr && off == 2'd2 && bus.sel_i != 4'd0;
        n_en = m_en; n_ar = m_ar; n_ien = m_ien; n_pend = m_pend;
        n_load = m_load; n_count = m_count; n_wait = m_wait;
        if (m_en) n_wait = tick ? DIV : m_wait - 1;
        if (wr && off == 2'd3 && bus.sel_i[0] && bus.data_i[0]) n_pend = 0;
        if (tick && !cnt_wr) begin
            if (m_count != 0) begin
                n_count = m_count - 1;
            end else begin
                n_pend = 1;
                if (m_ar) n_count = m_load;
                else      n_en = 0;
            end
        end
        if (wr && off == 2'd1) n_load = lanes(m_load, bus.data_i, bus.sel_i);
        if (cnt_wr) n_count = lanes(m_count, bus.data_i, bus.sel_i);
        if (wr && off == 2'd0 && bus.sel_i[0]) begin
            n_en = bus.data_i[0]; n_ar = bus.data_i[1]; n_ien = bus.data_i[2];
            if (bus.data_i[0] && !m_en) n_wait = DIV;
        end
        m_en = n_en; m_ar = n_ar; m_ien = n_ien; m_pend = n_pend;
        m_load = n_load; m_count = n_count; m_wait = n_wait;
    endtask

    always @(posedge clk) model_step();

    task automatic drive(input logic r, input logic ce, input logic we, input logic [31:0] addr,
                         input logic [3:0] sel, input logic [31:0] data);
        @(negedge clk);
        rst        = r;
        bus.ce_i   = ce;
        bus.we_i   = we;
        bus.addr_i = addr;
        bus.sel_i  = sel;
        bus.data_i = data;
        #1;
    endtask

    task automatic wr(input int off, input logic [3:0] sel, input logic [31:0] data);
        drive(1'b0, 1'b1, 1'b1, BASE + 32'(off * 4), sel, data);
    endtask

    task automatic rd(input int off);
        drive(1'b0, 1'b1, 1'b0, BASE + 32'(off * 4), 4'd0, 32'd0);
    endtask

    task automatic idle();
        drive(1'b0, 1'b0, 1'b0, 32'd0, 4'd0, 32'd0);
    endtask

    task automatic do_reset();
        drive(1'b1, 1'b0, 1'b0, 32'd0, 4'd0, 32'd0);
        idle();
    endtask

    task automatic test_reset();
        drive(1'b1, 1'b1, 1'b1, BASE, 4'hF, 32'd7);
        drive(1'b1, 1'b1, 1'b0, BASE, 4'h0, 32'd0);
        vectors++;
        if (bus.data_o !== 32'd0 || irq_o !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_outputs: data_o=%h irq=%b, required 0/0", bus.data_o, irq_o);
        end
        for (int off = 0; off < 4; off++) begin
            rd(off);
            vectors++;
            if (bus.data_o !== 32'd0 || irq_o !== 1'b0) begin
                miscompares++;
                $display("FAIL reset_reg%0d: data_o=%h irq=%b, required 0/0", off, bus.data_o, irq_o);
            end
        end
    endtask

    task automatic test_oneshot();
        do_reset();
        wr(2, 4'hF, 32'd3);
        wr(0, 4'hF, 32'd5);
        for (int j = 1; j <= 17; j++) begin
            idle();
            if (j >= 15) begin
                vectors++;
                if (irq_o !== (j == 17)) begin
                    miscompares++;
                    $display("FAIL oneshot_irq_cycle%0d: irq=%b, required %b", j, irq_o, (j == 17));
                end
            end
        end
        rd(0);
        vectors++;
        if (bus.data_o !== 32'd4) begin
            miscompares++;
            $display("FAIL oneshot_ctrl: got %h, required 00000004", bus.data_o);
        end
        rd(2);
        vectors++;
        if (bus.data_o !== 32'd0) begin
            miscompares++;
            $display("FAIL oneshot_count: got %h, required 00000000", bus.data_o);
        end
        wr(3, 4'h1, 32'd1);
        idle();
        vectors++;
        if (irq_o !== 1'b0) begin
            miscompares++;
            $display("FAIL oneshot_w1c: irq=%b, required 0", irq_o);
        end
    endtask

    task automatic test_autoreload();
        logic exp_irq;
        do_reset();
        wr(1, 4'hF, 32'd2);
        wr(2, 4'hF, 32'd2);
        wr(0, 4'hF, 32'd7);
        for (int j = 1; j <= 25; j++) begin
            if (j == 14) wr(3, 4'h1, 32'd1);
            else         idle();
            exp_irq = (j == 13) || (j == 14) || (j >= 25);
            vectors++;
            if (irq_o !== exp_irq) begin
                miscompares++;
                $display("FAIL autoreload_irq_cycle%0d: irq=%b, required %b", j, irq_o, exp_irq);
            end
        end
        wr(0, 4'hF, 32'd0);
        wr(3, 4'hF, 32'd1);
    endtask

    task automatic test_byte_enables();
        do_reset();
        wr(1, 4'hF, 32'd0);
        wr(1, 4'b0101, 32'hAABB_CCDD);
        rd(1);
        vectors++;
        if (bus.data_o !== 32'h00BB_00DD) begin
            miscompares++;
            $display("FAIL byte_lanes: got %h, required 00bb00dd", bus.data_o);
        end
        wr(1, 4'b0000, 32'h1122_3344);
        rd(1);
        vectors++;
        if (bus.data_o !== 32'h00BB_00DD) begin
            miscompares++;
            $display("FAIL sel_zero: got %h, required 00bb00dd", bus.data_o);
        end
        wr(2, 4'b1000, 32'hFF12_3456);
        rd(2);
        vectors++;
        if (bus.data_o !== 32'hFF00_0000) begin
            miscompares++;
            $display("FAIL count_lane3: got %h, required ff000000", bus.data_o);
        end
    endtask

    task automatic test_collisions();
        do_reset();
        wr(2, 4'hF, 32'd0);
        wr(0, 4'hF, 32'd5);
        for (int j = 1; j <= 3; j++) idle();
        wr(3, 4'h1, 32'd1);
        rd(3);
        vectors++;
        if (bus.data_o !== 32'd1 || irq_o !== 1'b1) begin
            miscompares++;
            $display("FAIL w1c_vs_expiry: stat=%h irq=%b, required 1/1", bus.data_o, irq_o);
        end
        wr(3, 4'h1, 32'd1);
        wr(0, 4'hF, 32'd0);

        wr(2, 4'hF, 32'd5);
        wr(0, 4'hF, 32'd1);
        for (int j = 1; j <= 3; j++) idle();
        wr(2, 4'hF, 32'd9);
        rd(2);
        vectors++;
        if (bus.data_o !== 32'd9) begin
            miscompares++;
            $display("FAIL count_write_vs_tick: got %h, required 00000009", bus.data_o);
        end
        for (int j = 6; j <= 8; j++) idle();
        rd(2);
        vectors++;
        if (bus.data_o !== 32'd8) begin
            miscompares++;
            $display("FAIL count_after_consumed_tick: got %h, required 00000008", bus.data_o);
        end
        wr(0, 4'hF, 32'd0);

        wr(2, 4'hF, 32'd0);
        wr(0, 4'hF, 32'd1);
        for (int j = 1; j <= 3; j++) idle();
        wr(0, 4'hF, 32'd3);
        rd(0);
        vectors++;
        if (bus.data_o !== 32'd3) begin
            miscompares++;
            $display("FAIL ctrl_write_vs_autoclear: got %h, required 00000003", bus.data_o);
        end
        wr(0, 4'hF, 32'd0);
    endtask

    task automatic test_decode();
        do_reset();
        wr(1, 4'hF, 32'h55);
        drive(1'b0, 1'b1, 1'b0, BASE + 32'h14, 4'h0, 32'd0);
        vectors++;
        if (bus.data_o !== 32'd0) begin
            miscompares++;
            $display("FAIL decode_read_outside: got %h, required 00000000", bus.data_o);
        end
        drive(1'b0, 1'b0, 1'b0, BASE + 32'h4, 4'h0, 32'd0);
        vectors++;
        if (bus.data_o !== 32'd0) begin
            miscompares++;
            $display("FAIL decode_read_no_ce: got %h, required 00000000", bus.data_o);
        end
        drive(1'b0, 1'b1, 1'b1, BASE + 32'h14, 4'hF, 32'h77);
        drive(1'b0, 1'b1, 1'b1, BASE + 32'h10, 4'hF, 32'h7);
        drive(1'b0, 1'b0, 1'b1, BASE + 32'h4, 4'hF, 32'h123);
        rd(1);
        vectors++;
        if (bus.data_o !== 32'h55) begin
            miscompares++;
            $display("FAIL decode_load_kept: got %h, required 00000055", bus.data_o);
        end
        rd(0);
        vectors++;
        if (bus.data_o !== 32'd0) begin
            miscompares++;
            $display("FAIL decode_ctrl_kept: got %h, required 00000000", bus.data_o);
        end
    endtask

    task automatic test_random();
        int          kind;
        int          off;
        logic        r;
        logic [3:0]  sel;
        logic [31:0] data;
        logic [31:0] exp_data;
        logic        exp_irq;
        do_reset();
        for (int n = 0; n < 3000; n++) begin
            r    = ($urandom_range(0, 299) == 0);
            kind = $urandom_range(0, 9);
            off  = $urandom_range(0, 3);
            sel  = ($urandom_range(0, 1) == 1) ? 4'hF : 4'($urandom_range(0, 15));
            data = $urandom();
            if (off == 0)      data[2:0] = 3'($urandom_range(0, 7));
            else if (off != 3) data = 32'($urandom_range(0, 5));
            if (kind <= 3)      drive(r, 1'b0, 1'b0, 32'd0, 4'd0, 32'd0);
            else if (kind <= 5) drive(r, 1'b1, 1'b0, BASE + 32'(off * 4), 4'd0, 32'd0);
            else if (kind <= 8) drive(r, 1'b1, 1'b1, BASE + 32'(off * 4), sel, data);
            else                drive(r, $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1,
                                      (BASE ^ 32'h0100_0010) + 32'(off * 4), sel, data);
            exp_data = model_read();
            exp_irq  = m_pend && m_ien && !rst;
            vectors++;
            if (bus.data_o !== exp_data || irq_o !== exp_irq) begin
                miscompares++;
                $display("FAIL random_step%0d: data_o=%h irq=%b, required %h/%b",
                         n, bus.data_o, irq_o, exp_data, exp_irq);
            end
        end
    endtask

    initial begin
        bus.ce_i   = 1'b0;
        bus.we_i   = 1'b0;
        bus.addr_i = '0;
        bus.sel_i  = '0;
        bus.data_i = '0;
        test_reset();
        test_oneshot();
        test_autoreload();
        test_byte_enables();
        test_collisions();
        test_decode();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
